// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU (push/stop handshake, 2-bit ctl, 8-bit a/b,
//            carry in/out) among N_REQ requesters. A round-robin arbiter
//            feeds a one-entry registered issue stage. Every op that
//            reaches the ALU leaves its requester index in an in-order tag
//            FIFO. Each ALU result is then steered back to the requester
//            whose tag is at the FIFO head.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_REQ      number of requesters (2..8)
//   TAG_DEPTH  max ops in flight, issue reg + ALU pipeline (power of 2, >=2)
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_pushin/req_stopout       per-requester op handshake
//   req_ctl/req_a/req_b/req_ci   packed per-requester op fields
//   rsp_pushout/rsp_stopin       per-requester result handshake
//   rsp_z/rsp_cout               broadcast result (ALU pass-through)
//   alu_pushin/alu_stopout       registered op handshake to the ALU
//   alu_ctl/alu_a/alu_b/alu_ci   registered op fields to the ALU
//   alu_pushout/alu_stopin       result handshake from the ALU
//   alu_z/alu_cout               ALU result
//   err_orphan                   sticky: result arrived with no tag queued
// Optional build macro
//   ALU_ARB_STATS_EN             adds op_count / stall_count outputs
// ============================================================================
module alu_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_pushin,
    output logic [N_REQ-1:0]     req_stopout,
    input  logic [2*N_REQ-1:0]   req_ctl,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_ci,
    output logic [N_REQ-1:0]     rsp_pushout,
    input  logic [N_REQ-1:0]     rsp_stopin,
    output logic [7:0]           rsp_z,
    output logic                 rsp_cout,
    output logic                 alu_pushin,
    input  logic                 alu_stopout,
    output logic [1:0]           alu_ctl,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic                 alu_ci,
    input  logic                 alu_pushout,
    output logic                 alu_stopin,
    input  logic [7:0]           alu_z,
    input  logic                 alu_cout,
    output logic                 err_orphan
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]          op_count,
    output logic [15:0]          stall_count
`endif
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               issue_valid_q, issue_valid_d;
    logic [1:0]         issue_ctl_q,   issue_ctl_d;
    logic [7:0]         issue_a_q,     issue_a_d;
    logic [7:0]         issue_b_q,     issue_b_d;
    logic               issue_ci_q,    issue_ci_d;
    logic [TAG_W-1:0]   issue_tag_q,   issue_tag_d;
    logic [TAG_W-1:0]   rr_q,          rr_d;
    logic [PTR_W-1:0]   wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q,    fifo_cnt_d;
    logic               err_orphan_q,  err_orphan_d;
    logic [TAG_W-1:0]   tag_mem_q [TAG_DEPTH];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_any_push;
    logic [TAG_W-1:0]   w_grant;
    logic               w_alu_fire;
    logic               w_room;
    logic               w_can_load;
    logic               w_req_xfer;
    logic               w_fifo_empty;
    logic [TAG_W-1:0]   w_head;
    logic               w_fifo_push;
    logic               w_fifo_pop;

    // Round-robin search: first pushing requester at or above rr_q,
    // wrapping modulo N_REQ.
    always_comb begin
        int idx;
        w_any_push = 1'b0;
        w_grant    = '0;
        idx        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_any_push && req_pushin[idx]) begin
                w_any_push = 1'b1;
                w_grant    = TAG_W'(idx);
            end
        end
    end

    assign w_alu_fire = issue_valid_q & ~alu_stopout;

    // Space is judged on the registered occupancy only; a result popping
    // in the same cycle does not make room until the next cycle.
    assign w_room     = (32'(fifo_cnt_q) + 32'(issue_valid_q)) < 32'(TAG_DEPTH);
    assign w_can_load = (~issue_valid_q | w_alu_fire) & w_room;
    assign w_req_xfer = w_any_push & w_can_load;

    always_comb begin
        req_stopout = '1;
        if (w_any_push) begin
            req_stopout[w_grant] = ~w_can_load;
        end
    end

    // ------------------------------------------------------------------
    // Issue register and round-robin pointer
    // ------------------------------------------------------------------
    always_comb begin
        int g;
        int nxt;
        issue_valid_d = issue_valid_q;
        issue_ctl_d   = issue_ctl_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_ci_d    = issue_ci_q;
        issue_tag_d   = issue_tag_q;
        rr_d          = rr_q;
        g             = int'(w_grant);
        nxt           = g + 1;
        if (nxt >= N_REQ) begin
            nxt = 0;
        end
        if (w_req_xfer) begin
            issue_valid_d = 1'b1;
            issue_ctl_d   = req_ctl[2*g +: 2];
            issue_a_d     = req_a[8*g +: 8];
            issue_b_d     = req_b[8*g +: 8];
            issue_ci_d    = req_ci[g];
            issue_tag_d   = w_grant;
            rr_d          = TAG_W'(nxt);
        end else if (w_alu_fire) begin
            issue_valid_d = 1'b0;
        end
    end

    assign alu_pushin = issue_valid_q;
    assign alu_ctl    = issue_ctl_q;
    assign alu_a      = issue_a_q;
    assign alu_b      = issue_b_q;
    assign alu_ci     = issue_ci_q;

    // ------------------------------------------------------------------
    // In-order tag FIFO
    // ------------------------------------------------------------------
    assign w_fifo_empty = (fifo_cnt_q == '0);
    assign w_head       = tag_mem_q[rd_ptr_q];
    assign w_fifo_push  = w_alu_fire;
    assign w_fifo_pop   = ~w_fifo_empty & alu_pushout & ~rsp_stopin[w_head];

    // Pointers wrap naturally because TAG_DEPTH is a power of two. The
    // occupancy guard on the issue stage means a push never hits a full FIFO.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (w_fifo_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_fifo_push, w_fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Response steering
    // ------------------------------------------------------------------
    // With no tag queued, a result has no owner: it is accepted
    // (alu_stopin low) and dropped, and the error flag latches.
    always_comb begin
        rsp_pushout  = '0;
        alu_stopin   = 1'b0;
        err_orphan_d = err_orphan_q | (w_fifo_empty & alu_pushout);
        if (!w_fifo_empty) begin
            rsp_pushout[w_head] = alu_pushout;
            alu_stopin          = rsp_stopin[w_head];
        end
    end

    assign rsp_z      = alu_z;
    assign rsp_cout   = alu_cout;
    assign err_orphan = err_orphan_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_ctl_q   <= '0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_ci_q    <= 1'b0;
            issue_tag_q   <= '0;
            rr_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            err_orphan_q  <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_ctl_q   <= issue_ctl_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_ci_q    <= issue_ci_d;
            issue_tag_q   <= issue_tag_d;
            rr_q          <= rr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk) begin
        if (!rst && w_fifo_push) begin
            tag_mem_q[wr_ptr_q] <= issue_tag_q;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [15:0] op_count_q,    op_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (w_alu_fire && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
        if (w_any_push && !w_req_xfer && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter (N_REQ=4, TAG_DEPTH=4).
//            Requester drivers feed per-requester op lists; every accepted
//            op pushes its expected result into a scoreboard queue, and a
//            monitor pops and compares at each result handshake. A small
//            ALU model accepts ops and returns results in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0] ctl;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
    } op_t;

    typedef struct {
        int         req;
        logic [7:0] z;
        logic       cout;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_pushin = '0;
    logic [N-1:0]   req_stopout;
    logic [2*N-1:0] req_ctl = '0;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic [N-1:0]   req_ci = '0;
    logic [N-1:0]   rsp_pushout;
    logic [N-1:0]   rsp_stopin = '0;
    logic [7:0]     rsp_z;
    logic           rsp_cout;
    logic           alu_pushin;
    logic           alu_stopout = 1'b0;
    logic [1:0]     alu_ctl;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic           alu_ci;
    logic           alu_pushout;
    logic           alu_stopin;
    logic [7:0]     alu_z;
    logic           alu_cout;
    logic           err_orphan;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_pushin(req_pushin), .req_stopout(req_stopout),
        .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .rsp_pushout(rsp_pushout), .rsp_stopin(rsp_stopin),
        .rsp_z(rsp_z), .rsp_cout(rsp_cout),
        .alu_pushin(alu_pushin), .alu_stopout(alu_stopout),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
        .alu_pushout(alu_pushout), .alu_stopin(alu_stopin),
        .alu_z(alu_z), .alu_cout(alu_cout),
        .err_orphan(err_orphan)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 00 add, 01 a + ~b + ci (subtract), 10 and, 11 xor
    function automatic logic [8:0] alu_ref(input op_t o);
        case (o.ctl)
            2'b00:   return {1'b0, o.a} + {1'b0, o.b} + {8'b0, o.ci};
            2'b01:   return {1'b0, o.a} + {1'b0, ~o.b} + {8'b0, o.ci};
            2'b10:   return {1'b0, o.a & o.b};
            default: return {1'b0, o.a ^ o.b};
        endcase
    endfunction

    // ---------------- requester drivers ----------------
    op_t ops [N][32];
    int  n_ops  [N];
    int  idx_r  [N];
    bit  pop_req[N];

    task automatic add_op(input int r, input op_t o);
        ops[r][n_ops[r]] = o;
        n_ops[r]++;
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_req[i]) begin
                idx_r[i]++;
                pop_req[i] = 1'b0;
            end
            if (idx_r[i] < n_ops[i]) begin
                req_pushin[i]    = 1'b1;
                req_ctl[2*i +: 2] = ops[i][idx_r[i]].ctl;
                req_a[8*i +: 8]   = ops[i][idx_r[i]].a;
                req_b[8*i +: 8]   = ops[i][idx_r[i]].b;
                req_ci[i]         = ops[i][idx_r[i]].ci;
            end else begin
                req_pushin[i]    = 1'b0;
                req_ctl[2*i +: 2] = 2'b00;
                req_a[8*i +: 8]   = 8'h00;
                req_b[8*i +: 8]   = 8'h00;
                req_ci[i]         = 1'b0;
            end
        end
    end

    // ---------------- ALU model ----------------
    op_t        alu_q[$];
    int         alu_cnt = 0;
    logic [8:0] model_res = '0;
    bit         alu_en = 1'b0;
    bit         orphan_force = 1'b0;
    bit         acc_f = 1'b0;
    bit         ret_f = 1'b0;
    op_t        acc_op;

    assign alu_pushout = orphan_force | (alu_en & (alu_cnt > 0));
    assign alu_z       = orphan_force ? 8'hA5 : model_res[7:0];
    assign alu_cout    = orphan_force ? 1'b0  : model_res[8];

    always @(posedge clk) begin
        #1;
        if (ret_f) void'(alu_q.pop_front());
        if (acc_f) alu_q.push_back(acc_op);
        acc_f   = 1'b0;
        ret_f   = 1'b0;
        alu_cnt = alu_q.size();
        model_res = (alu_cnt > 0) ? alu_ref(alu_q[0]) : 9'h000;
    end

    // ---------------- monitor / scoreboard ----------------
    exp_t exp_q[$];
    int   grant_log[$];
    int   xfer_count = 0;
    int   rsp_pops = 0;

    always @(negedge clk) begin
        int         nx;
        int         owner;
        logic [8:0] r;
        exp_t       e;
        // ALU model sees its handshakes regardless of rst: it is external.
        acc_f  = alu_pushin && !alu_stopout;
        acc_op = '{ctl: alu_ctl, a: alu_a, b: alu_b, ci: alu_ci};
        ret_f  = alu_pushout && !alu_stopin && !orphan_force && (alu_cnt > 0);
        if (rst) begin
            exp_q.delete();
        end else begin
            nx = 0;
            for (int i = 0; i < N; i++) begin
                if (req_pushin[i] && !req_stopout[i]) begin
                    nx++;
                    xfer_count++;
                    grant_log.push_back(i);
                    r = alu_ref(ops[i][idx_r[i]]);
                    exp_q.push_back('{req: i, z: r[7:0], cout: r[8]});
                    pop_req[i] = 1'b1;
                end
            end
            if (nx > 0) check("single_grant", 32'(nx), 32'd1);
            if (rsp_pushout != '0) begin
                owner = 0;
                for (int i = N - 1; i >= 0; i--) if (rsp_pushout[i]) owner = i;
                if (!rsp_stopin[owner]) begin
                    rsp_pops++;
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_pushout), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_owner", 32'(rsp_pushout), 32'(1 << e.req));
                        check("rsp_z", 32'(rsp_z), 32'(e.z));
                        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic nsync();
        @(negedge clk); #1;
    endtask

    task automatic psync();
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input int cycles);
        psync();
        rst = 1'b1;
        repeat (cycles) psync();
        rst = 1'b0;
    endtask

    function automatic bit all_sent();
        for (int i = 0; i < N; i++) if (idx_r[i] < n_ops[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int k;
        k = 0;
        while (k < 300 && !(all_sent() && exp_q.size() == 0 && alu_cnt == 0 && !alu_pushin)) begin
            nsync();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int x0;
        int k;
        int p0;
        int exp_g[6];
        exp_g = '{0, 1, 2, 3, 0, 1};

        repeat (3) psync();
        rst = 1'b0;

        // Reset state
        nsync();
        check("rst_alu_pushin", 32'(alu_pushin), 32'd0);
        check("rst_alu_ops", {21'd0, alu_ctl, alu_a, alu_ci}, 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_req_stopout", 32'(req_stopout), 32'hF);
        check("rst_rsp_pushout", 32'(rsp_pushout), 32'd0);
        check("rst_err_orphan", 32'(err_orphan), 32'd0);

        // Single add from requester 0: 5 + 3 = 8
        alu_en = 1'b1;
        add_op(0, '{ctl: 2'b00, a: 8'h05, b: 8'h03, ci: 1'b0});
        x0 = xfer_count;
        k = 0;
        while (k < 20 && xfer_count == x0) begin nsync(); k++; end
        check("t1_xfer", 32'(xfer_count - x0), 32'd1);
        nsync();
        check("t1_alu_pushin", 32'(alu_pushin), 32'd1);
        check("t1_alu_a", 32'(alu_a), 32'h05);
        check("t1_alu_b", 32'(alu_b), 32'h03);
        nsync();
        check("t1_rsp_pushout", 32'(rsp_pushout), 32'h1);
        check("t1_rsp_z", 32'(rsp_z), 32'h08);
        check("t1_rsp_cout", 32'(rsp_cout), 32'h0);
        drain("t1_drain");

        // All four push continuously from reset
        do_reset(1);
        nsync();
        grant_log.delete();
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < 3; j++) begin
                add_op(r, '{ctl: 2'(r), a: 8'(8'h30 + 16*r + j), b: 8'(8'h0F - j), ci: 1'(j)});
            end
        end
        drain("t2_drain");
        check("t2_grant_count", 32'(grant_log.size()), 32'd12);
        if (grant_log.size() >= 6) begin
            for (int j = 0; j < 6; j++) check("t2_grant_order", 32'(grant_log[j]), 32'(exp_g[j]));
        end

        // ALU holds results: exactly TAG_DEPTH ops accepted
        alu_en = 1'b0;
        nsync();
        x0 = xfer_count;
        for (int j = 0; j < 6; j++) add_op(0, '{ctl: 2'b11, a: 8'(8'h40 + j), b: 8'h0F, ci: 1'b0});
        repeat (12) nsync();
        check("t3_accept4", 32'(xfer_count - x0), 32'd4);
        check("t3_stopout_full", 32'(req_stopout), 32'hF);
        psync();
        alu_en = 1'b1;
        psync();
        alu_en = 1'b0;
        repeat (6) nsync();
        check("t3_accept5", 32'(xfer_count - x0), 32'd5);
        check("t3_stopout_full2", 32'(req_stopout), 32'hF);
        psync();
        alu_en = 1'b1;
        drain("t3_drain");

        // Result for tag 2 held by rsp_stopin[2] for 5 cycles: 0x10 - 0x01
        nsync();
        rsp_stopin = 4'b0100;
        add_op(2, '{ctl: 2'b01, a: 8'h10, b: 8'h01, ci: 1'b1});
        k = 0;
        while (k < 20 && rsp_pushout == '0) begin nsync(); k++; end
        p0 = rsp_pops;
        for (int j = 0; j < 5; j++) begin
            check("t4_hold_pushout", 32'(rsp_pushout), 32'h4);
            check("t4_hold_stopin", 32'(alu_stopin), 32'd1);
            check("t4_hold_z", 32'(rsp_z), 32'h0F);
            if (j < 4) nsync();
        end
        check("t4_hold_cout", 32'(rsp_cout), 32'd1);
        psync();
        rsp_stopin = 4'b0000;
        nsync();
        check("t4_release_stopin", 32'(alu_stopin), 32'd0);
        nsync();
        check("t4_single_pop", 32'(rsp_pops - p0), 32'd1);
        check("t4_after_pushout", 32'(rsp_pushout), 32'd0);
        drain("t4_drain");

        // Orphan result with nothing issued
        nsync();
        check("t5_err_before", 32'(err_orphan), 32'd0);
        psync();
        orphan_force = 1'b1;
        nsync();
        check("t5_orphan_stopin", 32'(alu_stopin), 32'd0);
        check("t5_orphan_pushout", 32'(rsp_pushout), 32'd0);
        psync();
        orphan_force = 1'b0;
        repeat (4) nsync();
        check("t5_err_sticky", 32'(err_orphan), 32'd1);
        do_reset(1);
        nsync();
        check("t5_err_cleared", 32'(err_orphan), 32'd0);

        // Reset with 3 ops in flight and the ALU input stalled
        alu_en = 1'b0;
        x0 = xfer_count;
        add_op(1, '{ctl: 2'b00, a: 8'h11, b: 8'h22, ci: 1'b0});
        add_op(1, '{ctl: 2'b10, a: 8'hF0, b: 8'h3C, ci: 1'b0});
        repeat (6) nsync();
        check("t6_two_in", 32'(xfer_count - x0), 32'd2);
        psync();
        alu_stopout = 1'b1;
        nsync();
        add_op(1, '{ctl: 2'b11, a: 8'h55, b: 8'hFF, ci: 1'b0});
        repeat (4) nsync();
        check("t6_three_in", 32'(xfer_count - x0), 32'd3);
        check("t6_issue_held", 32'(alu_pushin), 32'd1);
        do_reset(1);
        nsync();
        check("t6_rst_pushin", 32'(alu_pushin), 32'd0);
        check("t6_rst_alu_a", 32'(alu_a), 32'd0);
        check("t6_rst_err", 32'(err_orphan), 32'd0);
        psync();
        alu_stopout = 1'b0;
        alu_en = 1'b1;
        nsync();
        check("t6_stale_stopin", 32'(alu_stopin), 32'd0);
        check("t6_stale_pushout", 32'(rsp_pushout), 32'd0);
        nsync();
        check("t6_stale_err", 32'(err_orphan), 32'd1);
        k = 0;
        while (k < 10 && alu_cnt != 0) begin nsync(); k++; end
        grant_log.delete();
        add_op(3, '{ctl: 2'b00, a: 8'hFF, b: 8'h01, ci: 1'b0});
        add_op(0, '{ctl: 2'b01, a: 8'h00, b: 8'h01, ci: 1'b1});
        drain("t6_drain");
        check("t6_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("t6_rr_first", 32'(grant_log[0]), 32'd0);
            check("t6_rr_second", 32'(grant_log[1]), 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
